fir_output_buffer: RTL and testbench
====================================

Name: fir_output_buffer

Overview:
- Downstream stage of the FIR filter unit.
- Captures the MAC accumulator on every output-load strobe from the filter control FSM.
- Scales the accumulator to output sample width, with optional rounding and mandatory saturation.
- Buffers results in a small FIFO and delivers them to the sink over a valid/ready handshake; flags saturation and dropped samples.

Parameters:
- ACCBITS, 32: accumulator width (signed two's complement).
- DATABITS, 16: output sample width (signed).
- FRACBITS, 15: right-shift applied to the accumulator; legal range 1..ACCBITS-DATABITS.
- DEPTH, 4: FIFO depth in samples; power of two, ≥2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- filter_en_in  in  1  filter enable; low = flush/idle.
- oload_in  in  1  output-load strobe from filter control; acc_in is valid in the same cycle.
- acc_in  in  ACCBITS  signed accumulator value.
- dout_out  out  DATABITS  signed sample at FIFO head.
- dvalid_out  out  1  dout_out valid (FIFO non-empty).
- dready_in  in  1  sink accepts dout_out.
- level_out  out  $clog2(DEPTH+1)  FIFO occupancy.
- sat_out  out  1  sticky: at least one sample saturated.
- overflow_out  out  1  sticky: at least one sample dropped because the FIFO was full.

Behaviour:
- Reset (async, rst_n=0): pipeline register and valid cleared; FIFO pointers and count = 0; dout_out=0, dvalid_out=0, level_out=0, sat_out=0, overflow_out=0.
- Stage 1, convert:
  - At a rising edge with filter_en_in=1 and oload_in=1, register conv_r = sat(acc_in >>> FRACBITS, with rounding per the optional feature) and set conv_v=1.
  - Otherwise conv_v=0.
  - oload_in is ignored while filter_en_in=0.
- Shift is arithmetic and computed at ACCBITS+1 bits so the rounding add cannot wrap.
- Saturation:
  - Result > 2^(DATABITS-1)-1 clamps to 0x7FFF (for DATABITS=16).
  - Result < -2^(DATABITS-1) clamps to 0x8000.
  - Any clamp sets sat_out at the same edge conv_r is written.
- Stage 2, push: at the edge after conv_v=1, conv_r is written to the FIFO tail.
- Latency: oload_in sampled at edge N gives dvalid_out=1 after edge N+1 when the FIFO was empty. There is no bypass path.
- Pop: dvalid_out = (count≠0). dout_out is driven combinationally from the head entry and is 0 when empty. A transfer occurs on an edge where dvalid_out=1 and dready_in=1.
- Simultaneous push and pop: legal at any level, including full; count unchanged; order preserved.
- Full (count=DEPTH) with a push and no pop: sample discarded, FIFO contents unchanged, overflow_out set.
- Empty with dready_in=1: no action.
- Pointers wrap modulo DEPTH.
- Flush (filter_en_in=0 at an edge):
  - FIFO count and pointers cleared and conv_v cleared at that edge; dvalid_out=0 thereafter.
  - A pending conv_v sample is discarded and is not counted as an overflow.
  - sat_out and overflow_out are NOT cleared; only rst_n clears them.
- oload_in may be asserted on consecutive cycles; the block accepts one sample per cycle.

Optional Feature:
- Macro FIR_OUT_ROUND_EN.
- Defined: round half up. Add 2^(FRACBITS-1) before the arithmetic shift, then saturate.
- Undefined: truncation toward -inf (plain arithmetic shift), then saturate.
- All other behaviour is identical.

Test Plan (defaults ACCBITS=32, DATABITS=16, FRACBITS=15, DEPTH=4):
- Reset and idle: rst_n=0 then 1, no strobes → all outputs 0 for 4 cycles.
- Single sample:
  - Stimulus: filter_en_in=1, one oload_in pulse, acc_in=0x0001_8000, dready_in=1.
  - Response: dvalid_out=1 for exactly one cycle, two edges after the strobe edge; dout_out=0x0003; level_out returns to 0.
- Saturation and rounding:
  - acc_in=0x4000_0000 → dout_out=0x7FFF, sat_out=1.
  - acc_in=0xC000_0000 → dout_out=0x8000, no saturation.
  - acc_in=0x0000_4000 → dout_out=0x0001 with FIR_OUT_ROUND_EN, 0x0000 without.
- Full and overflow:
  - Stimulus: dready_in=0, five strobes with acc_in=k<<15 for k=1..5.
  - Response: level_out=4, overflow_out=1; after raising dready_in, dout_out sequence is 1,2,3,4, then dvalid_out=0.
- Push and pop at full: FIFO full, dready_in=1, strobes continuing every cycle → level_out stays 4, no new overflow, output order preserved.
- Flush:
  - Stimulus: two samples buffered, sat_out=1, then filter_en_in=0 for one edge.
  - Response: level_out=0 and dvalid_out=0 after that edge; sat_out still 1; a concurrent oload_in is ignored.

Source files
------------

// File: rtl/fir_output_buffer.sv
// fir_output_buffer: output stage of the FIR filter unit.
// Captures the MAC accumulator on each output-load strobe and scales it to
// sample width with saturation. Results are buffered in a small FIFO and
// handed to the sink over a valid/ready handshake.
// Optional feature macro: FIR_OUT_ROUND_EN (round half up before the shift;
// the default build truncates toward -inf).
module fir_output_buffer #(
  parameter int ACCBITS  = 32,
  parameter int DATABITS = 16,
  parameter int FRACBITS = 15,
  parameter int DEPTH    = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         filter_en_in,
  input  logic                         oload_in,
  input  logic signed [ACCBITS-1:0]    acc_in,
  output logic signed [DATABITS-1:0]   dout_out,
  output logic                         dvalid_out,
  input  logic                         dready_in,
  output logic [$clog2(DEPTH+1)-1:0]   level_out,
  output logic                         sat_out,
  output logic                         overflow_out
);

  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LVLW = $clog2(DEPTH+1);
  localparam logic [LVLW-1:0] FULL_LVL = LVLW'(DEPTH);

  // Output range limits, sign-extended to the ACCBITS+1 working width.
  localparam logic signed [ACCBITS:0] MAX_V =
    {{(ACCBITS-DATABITS+2){1'b0}}, {(DATABITS-1){1'b1}}};
  localparam logic signed [ACCBITS:0] MIN_V =
    {{(ACCBITS-DATABITS+2){1'b1}}, {(DATABITS-1){1'b0}}};

`ifdef FIR_OUT_ROUND_EN
  localparam logic signed [ACCBITS:0] RND_HALF = (ACCBITS+1)'(1) << (FRACBITS-1);
`endif

  // One extra bit of headroom so the rounding add can never wrap.
  function automatic logic signed [ACCBITS:0] scale_acc(
    input logic signed [ACCBITS-1:0] a);
    logic signed [ACCBITS:0] ext;
    ext = {a[ACCBITS-1], a};
`ifdef FIR_OUT_ROUND_EN
    ext = ext + RND_HALF;
`endif
    return ext >>> FRACBITS;
  endfunction

  function automatic logic sat_hit(input logic signed [ACCBITS:0] v);
    return (v > MAX_V) || (v < MIN_V);
  endfunction

  function automatic logic signed [DATABITS-1:0] sat_val(
    input logic signed [ACCBITS:0] v);
    if (v > MAX_V)
      return {1'b0, {(DATABITS-1){1'b1}}};
    else if (v < MIN_V)
      return {1'b1, {(DATABITS-1){1'b0}}};
    else
      return v[DATABITS-1:0];
  endfunction

  logic signed [ACCBITS:0]       scaled;
  logic signed [DATABITS-1:0]    conv_d, conv_q;
  logic                          conv_v_d, conv_v_q;
  logic                          sat_d, sat_q;
  logic                          ovf_d, ovf_q;
  logic [PTRW-1:0]               wr_ptr_d, wr_ptr_q;
  logic [PTRW-1:0]               rd_ptr_d, rd_ptr_q;
  logic [LVLW-1:0]               count_d, count_q;
  logic                          wr_en;
  logic                          pop;
  logic                          do_push;
  logic signed [DATABITS-1:0]    mem_q [DEPTH];

  // Stage 1: scale and saturate the accumulator on a qualified strobe.
  always_comb begin
    scaled   = scale_acc(acc_in);
    conv_d   = conv_q;
    conv_v_d = 1'b0;
    sat_d    = sat_q;
    if (filter_en_in && oload_in) begin
      conv_d   = sat_val(scaled);
      conv_v_d = 1'b1;
      if (sat_hit(scaled))
        sat_d = 1'b1;
    end
  end

  // Stage 2: FIFO bookkeeping; a pop frees a slot for a same-edge push even when full.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    wr_en    = 1'b0;
    pop      = dvalid_out && dready_in;
    do_push  = conv_v_q && ((count_q != FULL_LVL) || pop);
    if (!filter_en_in) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (conv_v_q && (count_q == FULL_LVL) && !pop)
        ovf_d = 1'b1;
      if (do_push) begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + PTRW'(1);
      end
      if (pop)
        rd_ptr_d = rd_ptr_q + PTRW'(1);
      count_d = count_q + LVLW'(do_push) - LVLW'(pop);
    end
  end

  // Control and pipeline state with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conv_q   <= '0;
      conv_v_q <= 1'b0;
      sat_q    <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      conv_q   <= conv_d;
      conv_v_q <= conv_v_d && filter_en_in;
      sat_q    <= sat_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; contents are only meaningful where count says so.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem_q[wr_ptr_q] <= conv_q;
  end

  assign dvalid_out   = (count_q != '0);
  assign dout_out     = dvalid_out ? mem_q[rd_ptr_q] : '0;
  assign level_out    = count_q;
  assign sat_out      = sat_q;
  assign overflow_out = ovf_q;

endmodule

// File: tb/tb_fir_output_buffer.sv
// Randomized and directed bench for fir_output_buffer with a queue-based
// reference model of the scale/saturate/FIFO behaviour.
module tb_fir_output_buffer;

  localparam int ACCBITS  = 32;
  localparam int DATABITS = 16;
  localparam int FRACBITS = 15;
  localparam int DEPTH    = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                filter_en_in = 1'b0;
  logic                oload_in = 1'b0;
  logic [ACCBITS-1:0]  acc_in = '0;
  logic                dready_in = 1'b0;
  logic [DATABITS-1:0] dout_out;
  logic                dvalid_out;
  logic [2:0]          level_out;
  logic                sat_out;
  logic                overflow_out;

  fir_output_buffer #(
    .ACCBITS(ACCBITS), .DATABITS(DATABITS), .FRACBITS(FRACBITS), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .filter_en_in(filter_en_in), .oload_in(oload_in),
    .acc_in(acc_in), .dout_out(dout_out), .dvalid_out(dvalid_out),
    .dready_in(dready_in), .level_out(level_out), .sat_out(sat_out),
    .overflow_out(overflow_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  int mq[$];
  bit pend_v   = 1'b0;
  int pend_val = 0;
  bit m_sat    = 1'b0;
  bit m_ovf    = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] u16(input int v);
    return 64'(v & 32'hFFFF);
  endfunction

  // Reference conversion: real-valued scaling by 2^-FRACBITS, floor, clamp.
  function automatic int conv(input logic [31:0] a, output bit s);
    longint x;
    x = longint'($signed(a));
`ifdef FIR_OUT_ROUND_EN
    x = x + (longint'(1) << (FRACBITS-1));
`endif
    x = x >>> FRACBITS;
    s = 1'b0;
    if (x > 32767) begin
      x = 32767; s = 1'b1;
    end else if (x < -32768) begin
      x = -32768; s = 1'b1;
    end
    return int'(x);
  endfunction

  task automatic model_edge();
    bit s;
    int v;
    bit pop;
    if (!filter_en_in) begin
      mq.delete();
      pend_v = 1'b0;
    end else begin
      pop = (mq.size() != 0) && dready_in;
      if (pop) void'(mq.pop_front());
      if (pend_v) begin
        if (mq.size() < DEPTH) mq.push_back(pend_val);
        else m_ovf = 1'b1;
      end
      pend_v = 1'b0;
      if (oload_in) begin
        v = conv(acc_in, s);
        pend_v = 1'b1;
        pend_val = v;
        if (s) m_sat = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    chk("dvalid", 64'(dvalid_out), 64'(mq.size() != 0));
    chk("dout", 64'(dout_out), (mq.size() != 0) ? u16(mq[0]) : 64'd0);
    chk("level", 64'(level_out), 64'(mq.size()));
    chk("sat", 64'(sat_out), 64'(m_sat));
    chk("overflow", 64'(overflow_out), 64'(m_ovf));
  endtask

  task automatic drive(input bit en, input bit ol, input logic [31:0] acc, input bit rdy);
    filter_en_in = en;
    oload_in     = ol;
    acc_in       = acc;
    dready_in    = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    logic [31:0] r;
    // Reset and idle
    repeat (2) @(negedge clk);
    compare_all();
    chk("rst_dvalid", 64'(dvalid_out), 64'd0);
    rst_n = 1'b1;
    drive(1, 0, 32'h0, 0);
    repeat (4) step();
    chk("idle_level", 64'(level_out), 64'd0);

    // Single sample: visible exactly one cycle, two edges after the strobe edge
    drive(1, 1, 32'h0001_8000, 1);
    step();
    chk("single_lat0", 64'(dvalid_out), 64'd0);
    drive(1, 0, 32'h0, 1);
    step();
    chk("single_valid", 64'(dvalid_out), 64'd1);
    chk("single_dout", 64'(dout_out), 64'h0003);
    step();
    chk("single_gone", 64'(dvalid_out), 64'd0);
    chk("single_level", 64'(level_out), 64'd0);

    // Most negative value in range: no saturation
    drive(1, 1, 32'hC000_0000, 0);
    step();
    drive(1, 0, 32'h0, 0);
    step();
    chk("neg_edge_dout", 64'(dout_out), 64'h8000);
    chk("neg_edge_nosat", 64'(sat_out), 64'd0);
    drive(1, 0, 32'h0, 1);
    step();

    // Positive saturation
    drive(1, 1, 32'h4000_0000, 0);
    step();
    drive(1, 0, 32'h0, 0);
    step();
    chk("pos_sat_dout", 64'(dout_out), 64'h7FFF);
    chk("pos_sat_flag", 64'(sat_out), 64'd1);
    drive(1, 0, 32'h0, 1);
    step();

    // Rounding of a half-LSB value
    drive(1, 1, 32'h0000_4000, 0);
    step();
    drive(1, 0, 32'h0, 0);
    step();
`ifdef FIR_OUT_ROUND_EN
    chk("round_half", 64'(dout_out), 64'h0001);
`else
    chk("round_half", 64'(dout_out), 64'h0000);
`endif
    drive(1, 0, 32'h0, 1);
    step();

    // Push and pop at full: level holds at DEPTH, no overflow
    for (int k = 1; k <= 5; k++) begin
      drive(1, 1, 32'(k) << 15, 0);
      step();
    end
    chk("full_level", 64'(level_out), 64'd4);
    for (int k = 6; k <= 13; k++) begin
      drive(1, 1, 32'(k) << 15, 1);
      step();
      chk("pp_level", 64'(level_out), 64'd4);
    end
    chk("pp_no_ovf", 64'(overflow_out), 64'd0);
    drive(1, 0, 32'h0, 1);
    repeat (6) step();

    // Full and overflow
    for (int k = 1; k <= 5; k++) begin
      drive(1, 1, 32'(k) << 15, 0);
      step();
    end
    drive(1, 0, 32'h0, 0);
    repeat (2) step();
    chk("ovf_level", 64'(level_out), 64'd4);
    chk("ovf_flag", 64'(overflow_out), 64'd1);
    drive(1, 0, 32'h0, 1);
    for (int k = 1; k <= 4; k++) begin
      chk("ovf_order", 64'(dout_out), u16(k));
      step();
    end
    chk("ovf_drained", 64'(dvalid_out), 64'd0);

    // Flush with buffered samples, a pending sample and a concurrent strobe
    for (int k = 1; k <= 3; k++) begin
      drive(1, 1, 32'(k) << 15, 0);
      step();
    end
    chk("flush_pre", 64'(level_out), 64'd2);
    drive(0, 1, 32'h0002_0000, 0);
    step();
    chk("flush_level", 64'(level_out), 64'd0);
    chk("flush_dvalid", 64'(dvalid_out), 64'd0);
    chk("flush_sat", 64'(sat_out), 64'd1);
    drive(1, 0, 32'h0, 0);
    repeat (2) step();
    chk("flush_ignored", 64'(dvalid_out), 64'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      r = $urandom;
      if ($urandom_range(0, 1) == 1)
        r = {{12{r[19]}}, r[19:0]};
      drive($urandom_range(0, 15) != 0, $urandom_range(0, 1) == 1, r,
            $urandom_range(0, 2) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
